dmem_port_arbiter: RTL and testbench

//  Shares the single-port, word-addressed data memory between two requesters: port 0 (CPU load/store)
//  and port 1 (debug/DMA loader). Arbitrates and registers each request, then drives the memory for one

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_arb_pick.sv | 31 +++
 rtl/dmem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Optional build macro DMEM_ARB_RR_EN selects round-robin arbitration.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DMEM_ADDR_BASE = 32'h0000_3000;
  localparam logic [31:0] DMEM_ADDR_TOP  = 32'h0000_3FFC;

  typedef logic port_id_t;

  // Legal access: inside the window (unsigned, inclusive) and word aligned.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] top);
    return (addr >= base) && (addr <= top) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way request picker producing a one-hot grant.
// DMEM_ARB_RR_EN defined: ptr names the preferred port on contention.
// DMEM_ARB_RR_EN undefined: port 0 always wins and there is no ptr input.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  port_id_t   ptr,
`endif
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // Combinational grant selection.
  always_comb begin
    grant = 2'b00;
`ifdef DMEM_ARB_RR_EN
    if (ptr == 1'b1) begin
      grant[1] = valid[1];
      grant[0] = valid[0] & ~valid[1];
    end else begin
      grant[0] = valid[0];
      grant[1] = valid[1] & ~valid[0];
    end
`else
    grant[0] = valid[0];
    grant[1] = valid[1] & ~valid[0];
`endif
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port word-addressed data memory between the CPU (port 0)
// and the debug/DMA loader (port 1). One transaction in flight at a time.
// Build macro DMEM_ARB_RR_EN: round-robin between ports instead of port 0 priority.
//
//  state  | meaning
//  IDLE   | waiting for a request; winner sees req_ready
//  ACCESS | memory driven for one cycle with the latched request
//  RESP   | response held on the latched port until rsp_ready
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DMEM_ADDR_BASE,
  parameter logic [31:0] ADDR_TOP  = DMEM_ADDR_TOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_rsp_valid,
  input  logic        p0_rsp_ready,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_rsp_valid,
  input  logic        p1_rsp_ready,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  port_id_t    port_q;
  logic        we_q;
  logic        ok_q;
  logic [1:0]  rsp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [1:0]  grant;
  logic        accept;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
  port_id_t ptr_q;

  dmem_arb_pick u_pick (
    .ptr   (ptr_q),
    .valid ({p1_req_valid, p0_req_valid}),
    .grant (grant)
  );

  // Preference flips after every accepted request so contention alternates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= ~ptr_q;
    end
  end
`else
  dmem_arb_pick u_pick (
    .valid ({p1_req_valid, p0_req_valid}),
    .grant (grant)
  );
`endif

  // Ready is gated by reset so nothing is accepted while rst_n is low.
  assign p0_req_ready = rst_n & (state == IDLE) & grant[0];
  assign p1_req_ready = rst_n & (state == IDLE) & grant[1];
  assign accept       = p0_req_ready | p1_req_ready;

  assign sel_we    = grant[1] ? p1_req_we    : p0_req_we;
  assign sel_addr  = grant[1] ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = grant[1] ? p1_req_wdata : p0_req_wdata;

  assign p0_rsp_valid = rsp_valid_q[0];
  assign p1_rsp_valid = rsp_valid_q[1];
  assign p0_rsp_rdata = rsp_valid_q[0] ? rdata_q : 32'h0;
  assign p1_rsp_rdata = rsp_valid_q[1] ? rdata_q : 32'h0;
  assign p0_rsp_err   = rsp_valid_q[0] & err_q;
  assign p1_rsp_err   = rsp_valid_q[1] & err_q;

  // Transaction FSM; memory controls are registered so they are live exactly during ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      ok_q        <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      rsp_valid_q <= 2'b00;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            port_q    <= grant[1];
            we_q      <= sel_we;
            ok_q      <= addr_ok(sel_addr, ADDR_BASE, ADDR_TOP);
            mem_we    <= sel_we & addr_ok(sel_addr, ADDR_BASE, ADDR_TOP);
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we      <= 1'b0;
          rdata_q     <= (!we_q && ok_q) ? mem_rdata : 32'h0;
          err_q       <= ~ok_q;
          rsp_valid_q <= (port_q == 1'b1) ? 2'b10 : 2'b01;
          state       <= RESP;
        end
        RESP: begin
          if (|(rsp_valid_q & {p1_rsp_ready, p0_rsp_ready})) begin
            rsp_valid_q <= 2'b00;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level memory model.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req_valid = 1'b0, p0_req_we = 1'b0;
  logic [31:0] p0_req_addr = 32'h0, p0_req_wdata = 32'h0;
  logic        p0_rsp_ready = 1'b0;
  logic        p1_req_valid = 1'b0, p1_req_we = 1'b0;
  logic [31:0] p1_req_addr = 32'h0, p1_req_wdata = 32'h0;
  logic        p1_rsp_ready = 1'b0;
  logic        p0_req_ready, p1_req_ready;
  logic        p0_rsp_valid, p1_rsp_valid;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
  logic        p0_rsp_err, p1_rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int rr_ptr = 0;
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  // Memory seen by the DUT: combinational read, write on the clock edge.
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  dmem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int port, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_req_valid = v; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = wdata;
    end else begin
      p1_req_valid = v; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = wdata;
    end
  endtask

  task automatic set_rsp_ready(input int port, input logic r);
    if (port == 0) p0_rsp_ready = r; else p1_rsp_ready = r;
  endtask

  function automatic logic get_ready(input int port);
    return (port == 0) ? p0_req_ready : p1_req_ready;
  endfunction

  function automatic logic get_rsp_valid(input int port);
    return (port == 0) ? p0_rsp_valid : p1_rsp_valid;
  endfunction

  function automatic logic [31:0] get_rdata(input int port);
    return (port == 0) ? p0_rsp_rdata : p1_rsp_rdata;
  endfunction

  function automatic logic get_err(input int port);
    return (port == 0) ? p0_rsp_err : p1_rsp_err;
  endfunction

  function automatic bit legal(input logic [31:0] addr);
    return (addr >= 32'h3000) && (addr <= 32'h3FFC) && (addr % 4 == 0);
  endfunction

  // Winner when both ports ask at once, from the arbitration rule alone.
  function automatic int model_winner();
`ifdef DMEM_ARB_RR_EN
    return rr_ptr;
`else
    return 0;
`endif
  endfunction

  // One full transaction on a port that is alone in asking at entry (called at a negedge in IDLE).
  // other_pending raises a read on the other port right after acceptance.
  task automatic txn(input int port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold, input bit other_pending);
    bit ok;
    int idx, base;
    logic [31:0] exp_rd;
    ok = legal(addr);
    idx = int'((addr - 32'h3000) / 4);
    exp_rd = 32'h0;
    if (!we && ok && ref_mem.exists(idx)) exp_rd = ref_mem[idx];
    set_req(port, 1'b1, we, addr, wdata);
    #1;
    check("req_ready_winner", {31'h0, get_ready(port)}, 32'h1);
    check("req_ready_idle_other", {31'h0, get_ready(1 - port)}, 32'h0);
    @(posedge clk);
    rr_ptr = 1 - rr_ptr;
    base = we_cnt;
    @(negedge clk);
    set_req(port, 1'b0, 1'b0, 32'h0, 32'h0);
    if (other_pending) set_req(1 - port, 1'b1, 1'b0, 32'h3004, 32'h0);
    #1;
    check("access_rsp_valid", {31'h0, get_rsp_valid(port)}, 32'h0);
    check("access_mem_we", {31'h0, mem_we}, {31'h0, we & ok});
    if (other_pending) check("access_other_ready", {31'h0, get_ready(1 - port)}, 32'h0);
    @(negedge clk);
    check("resp_valid_latency", {31'h0, get_rsp_valid(port)}, 32'h1);
    check("resp_rdata", get_rdata(port), exp_rd);
    check("resp_err", {31'h0, get_err(port)}, {31'h0, !ok});
    check("resp_other_valid", {31'h0, get_rsp_valid(1 - port)}, 32'h0);
    check("write_commits", we_cnt - base, (we && ok) ? 1 : 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", {31'h0, get_rsp_valid(port)}, 32'h1);
      check("hold_rdata", get_rdata(port), exp_rd);
      check("hold_err", {31'h0, get_err(port)}, {31'h0, !ok});
      if (other_pending) check("hold_other_ready", {31'h0, get_ready(1 - port)}, 32'h0);
    end
    set_rsp_ready(port, 1'b1);
    @(negedge clk);
    set_rsp_ready(port, 1'b0);
    check("resp_done", {31'h0, get_rsp_valid(port)}, 32'h0);
    check("mem_we_idle", {31'h0, mem_we}, 32'h0);
    if (we && ok) ref_mem[idx] = wdata;
  endtask

  initial begin
    logic [31:0] a;
    int w, sel;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_p0_ready", {31'h0, p0_req_ready}, 32'h0);
    check("rst_p1_ready", {31'h0, p1_req_ready}, 32'h0);
    check("rst_p0_rsp_valid", {31'h0, p0_rsp_valid}, 32'h0);
    check("rst_p1_rsp_valid", {31'h0, p1_rsp_valid}, 32'h0);
    check("rst_p0_err", {31'h0, p0_rsp_err}, 32'h0);
    check("rst_p0_rdata", p0_rsp_rdata, 32'h0);
    check("rst_p1_rdata", p1_rsp_rdata, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read back on port 0
    txn(0, 1'b1, 32'h3000, 32'hDEADBEEF, 0, 1'b0);
    txn(0, 1'b0, 32'h3000, 32'h0, 0, 1'b0);

    // Port 1 illegal writes, then boundary reads
    txn(1, 1'b1, 32'h4000, 32'h12345678, 0, 1'b0);
    txn(1, 1'b1, 32'h3002, 32'h12345678, 0, 1'b0);
    txn(1, 1'b0, 32'h3FFC, 32'h0, 0, 1'b0);
    txn(1, 1'b0, 32'h2FFC, 32'h0, 0, 1'b0);
    txn(0, 1'b1, 32'h3FFC, 32'hA5A5_0001, 0, 1'b0);
    txn(1, 1'b0, 32'h3FFC, 32'h0, 0, 1'b0);

    // Back-pressure on port 0 while port 1 waits; then port 1 is served
    txn(0, 1'b0, 32'h3000, 32'h0, 5, 1'b1);
    txn(1, 1'b0, 32'h3004, 32'h0, 0, 1'b0);

    // Continuous contention, both reading, responses consumed at once
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h3000, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h3FFC, 32'h0);
    for (int g = 0; g < 6; g++) begin
      #1;
      w = model_winner();
      check("contend_winner_ready", {31'h0, get_ready(w)}, 32'h1);
      check("contend_loser_ready", {31'h0, get_ready(1 - w)}, 32'h0);
      @(posedge clk);
      rr_ptr = 1 - rr_ptr;
      repeat (2) @(negedge clk);
      check("contend_rsp_valid", {31'h0, get_rsp_valid(w)}, 32'h1);
      check("contend_rdata", get_rdata(w), (w == 0) ? 32'hDEADBEEF : 32'hA5A5_0001);
      @(negedge clk);
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    p0_rsp_ready = 1'b0;
    p1_rsp_ready = 1'b0;
    @(negedge clk);

    // Reset during ACCESS of a write abandons it
    txn(0, 1'b1, 32'h3010, 32'h1111_1111, 0, 1'b0);
    set_req(0, 1'b1, 1'b1, 32'h3010, 32'h2222_2222);
    @(posedge clk);
    w = we_cnt;
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("pre_reset_mem_we", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_we", {31'h0, mem_we}, 32'h0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    check("midrst_rsp_valid", {31'h0, p0_rsp_valid}, 32'h0);
    check("midrst_no_write", we_cnt - w, 0);
    rst_n = 1'b1;
    rr_ptr = 0;
    @(negedge clk);
    txn(0, 1'b0, 32'h3010, 32'h0, 0, 1'b0);

    // Randomized traffic against the memory model
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 7));
      a = 32'h3000 + 4 * $urandom_range(0, 1023);
      if (sel == 5) a = a + $urandom_range(1, 3);
      else if (sel == 6) a = 32'h2FFC;
      else if (sel == 7) a = ($urandom_range(0, 1) == 0) ? 32'h4000 : 32'hFFFF_FFFC;
      txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
          int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
